// File: rtl/display_scan_driver.sv
// Time-multiplexed seven-segment scan driver: prescaled digit scan, frame-synchronous
// shadow register, per-digit enables, decimal points and leading-zero blanking.
module display_scan_driver #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int IDX_W       = $clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  blank_lz,
  output logic [N_DIGITS-1:0]   anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

  logic [PW-1:0]         pre_cnt;
  logic                  tick;
  logic                  wrap;
  logic [4*N_DIGITS-1:0] pending_hex;
  logic [N_DIGITS-1:0]   pending_dp;
  logic                  pend_v;
  logic [4*N_DIGITS-1:0] shadow_hex;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [N_DIGITS-1:0]   blank;
  logic                  lz_run;
  logic [N_DIGITS-1:0]   onehot;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_on;

  assign tick = (pre_cnt == PRE_MAX);
  assign wrap = tick && (digit_idx == IDX_MAX);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt    <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      pre_cnt    <= tick ? '0 : pre_cnt + 1'b1;
      frame_done <= wrap;
      if (tick)
        digit_idx <= wrap ? '0 : digit_idx + 1'b1;
    end
  end

  // A load coinciding with the wrap bypasses pending straight into shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_hex <= '0;
      pending_dp  <= '0;
      pend_v      <= 1'b0;
      shadow_hex  <= '0;
      shadow_dp   <= '0;
    end else if (wrap) begin
      pend_v <= 1'b0;
      if (load) begin
        shadow_hex <= hex_in;
        shadow_dp  <= dp_in;
      end else if (pend_v) begin
        shadow_hex <= pending_hex;
        shadow_dp  <= pending_dp;
      end
    end else if (load) begin
      pending_hex <= hex_in;
      pending_dp  <= dp_in;
      pend_v      <= 1'b1;
    end
  end

  // Blanking run starts at the top digit and stops at the first nonzero nibble or lit dp.
  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    for (int unsigned j = 0; j < N_DIGITS - 1; j++) begin
      lz_run = lz_run && (shadow_hex[4*(N_DIGITS-1-j) +: 4] == 4'h0)
                      && !shadow_dp[N_DIGITS-1-j];
      blank[N_DIGITS-1-j] = lz_run && blank_lz;
    end
  end

  always_comb begin
    onehot  = '0;
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_on  = 1'b0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (IDX_W'(k) == digit_idx) begin
        onehot[k] = 1'b1;
        cur_nib   = shadow_hex[4*k +: 4];
        cur_dp    = shadow_dp[k];
        cur_on    = digit_en[k] && !blank[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode <= '1;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end else if (cur_on) begin
      anode <= ~onehot;
      seg   <= hex7(cur_nib);
      dp    <= ~cur_dp;
    end else begin
      anode <= '1;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver: scan order, shadow updates, blanking,
// digit enables, non-power-of-2 scan and asynchronous reset.
module tb_display_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] hex_in;
  logic [7:0]  dp_in;
  logic        load;
  logic [7:0]  digit_en;
  logic        blank_lz;
  logic [7:0]  anode;
  logic [6:0]  seg;
  logic        dp_o;
  logic [2:0]  digit_idx;
  logic        frame_done;

  logic [23:0] hex2 = '0;
  logic [5:0]  dpin2 = '0;
  logic [5:0]  en2 = '1;
  logic [5:0]  anode2;
  logic [6:0]  seg2;
  logic        dp2;
  logic [2:0]  idx2;
  logic        fd2;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  display_scan_driver #(.N_DIGITS(8), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .hex_in(hex_in), .dp_in(dp_in), .load(load),
    .digit_en(digit_en), .blank_lz(blank_lz), .anode(anode), .seg(seg),
    .dp(dp_o), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  display_scan_driver #(.N_DIGITS(6), .REFRESH_DIV(2)) dut6 (
    .clk(clk), .reset(reset), .hex_in(hex2), .dp_in(dpin2), .load(1'b0),
    .digit_en(en2), .blank_lz(1'b0), .anode(anode2), .seg(seg2),
    .dp(dp2), .digit_idx(idx2), .frame_done(fd2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!frame_done && cnt < 200);
    check("frame_wait", {31'b0, frame_done}, 32'd1);
  endtask

  // Called at the negedge where frame_done is high; checks the following frame.
  task automatic scan_frame(input string tag, input logic [7:0] lit,
                            input logic [55:0] segs, input logic [7:0] dpm);
    logic [7:0] ea;
    logic [6:0] es;
    logic       ed;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ea = lit[i] ? ~(8'h01 << i) : 8'hFF;
      es = lit[i] ? segs[7*i +: 7] : 7'h7F;
      ed = lit[i] ? ~dpm[i] : 1'b1;
      check($sformatf("%s_an%0d", tag, i), {24'b0, anode}, {24'b0, ea});
      check($sformatf("%s_seg%0d", tag, i), {25'b0, seg}, {25'b0, es});
      check($sformatf("%s_dp%0d", tag, i), {31'b0, dp_o}, {31'b0, ed});
      if (i < 7) repeat (4) @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [31:0] h, input logic [7:0] d);
    hex_in = h;
    dp_in  = d;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hex_in = '0; dp_in = '0; load = 1'b0;
    digit_en = 8'hFF; blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_anode", {24'b0, anode}, 32'hFF);
    check("rst_seg", {25'b0, seg}, 32'h7F);
    check("rst_dp", {31'b0, dp_o}, 32'd1);
    check("rst_fd", {31'b0, frame_done}, 32'd0);
    check("rst_idx", {29'b0, digit_idx}, 32'd0);
    check("rst_pendv", {31'b0, dut.pend_v}, 32'd0);

    // Scan order; load during the first frame shows from the second frame on.
    reset = 1'b0;
    hex_in = 32'h76543210; dp_in = '0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("first_anode", {24'b0, anode}, 32'hFE);
    check("first_seg", {25'b0, seg}, 32'h40);
    check("first_pendv", {31'b0, dut.pend_v}, 32'd1);
    repeat (4) @(negedge clk);
    check("second_anode", {24'b0, anode}, 32'hFD);
    check("second_idx", {29'b0, digit_idx}, 32'd1);
    wait_frame(n);
    check("first_wrap_cycles", n, 32'd27);
    check("wrap_pendv", {31'b0, dut.pend_v}, 32'd0);
    scan_frame("scan", 8'hFF,
               {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 8'h00);
    wait_frame(n);
    wait_frame(n);
    check("frame_period", n, 32'd32);
    @(negedge clk);
    check("fd_one_cycle", {31'b0, frame_done}, 32'd0);

    // Tear-free update
    wait_frame(n);
    repeat (10) @(negedge clk);
    do_load(32'h11111111, 8'h00);
    check("tear_pendv", {31'b0, dut.pend_v}, 32'd1);
    check("tear_old_anode", {24'b0, anode}, 32'hFB);
    check("tear_old_seg", {25'b0, seg}, 32'h24);
    wait_frame(n);
    scan_frame("ones", 8'hFF, {8{7'h79}}, 8'h00);

    // Two loads in a frame: last one wins
    wait_frame(n);
    repeat (5) @(negedge clk);
    do_load(32'h22222222, 8'h00);
    repeat (5) @(negedge clk);
    do_load(32'h33333333, 8'h00);
    wait_frame(n);
    scan_frame("twoload", 8'hFF, {8{7'h30}}, 8'h00);

    // Load exactly on the wrapping tick
    wait_frame(n);
    repeat (31) @(negedge clk);
    do_load(32'hAAAAAAAA, 8'h00);
    check("onwrap_fd", {31'b0, frame_done}, 32'd1);
    check("onwrap_pendv", {31'b0, dut.pend_v}, 32'd0);
    scan_frame("onwrap", 8'hFF, {8{7'h08}}, 8'h00);

    // Leading-zero blanking
    wait_frame(n);
    repeat (3) @(negedge clk);
    blank_lz = 1'b1;
    do_load(32'h00000305, 8'h00);
    wait_frame(n);
    scan_frame("lz", 8'h07,
               {7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h12}, 8'h00);
    wait_frame(n);
    repeat (3) @(negedge clk);
    do_load(32'h00000305, 8'h20);
    wait_frame(n);
    scan_frame("lzdp", 8'h3F,
               {7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h12}, 8'h20);

    // Digit enables
    wait_frame(n);
    repeat (3) @(negedge clk);
    blank_lz = 1'b0;
    digit_en = 8'h0F;
    do_load(32'h76543210, 8'h00);
    wait_frame(n);
    scan_frame("en", 8'h0F,
               {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 8'h00);

    // Asynchronous reset with a pending load outstanding
    digit_en = 8'hFF;
    wait_frame(n);
    repeat (3) @(negedge clk);
    do_load(32'h12345678, 8'hFF);
    repeat (2) @(negedge clk);
    check("pre_rst_pendv", {31'b0, dut.pend_v}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_anode", {24'b0, anode}, 32'hFF);
    check("arst_seg", {25'b0, seg}, 32'h7F);
    check("arst_dp", {31'b0, dp_o}, 32'd1);
    check("arst_idx", {29'b0, digit_idx}, 32'd0);
    check("arst_pendv", {31'b0, dut.pend_v}, 32'd0);
    dp_in = '0;
    @(negedge clk);
    reset = 1'b0;

    // Six-digit instance scans 0..5 and wraps
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      check($sformatf("n6_idx%0d", j), {29'b0, idx2}, j % 6);
      @(negedge clk);
    end
    wait_frame(n);
    scan_frame("postrst", 8'hFF, {8{7'h40}}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
